// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives PC commands, issues memory reads and
// presents each fetched byte to the decoder with a valid/ready handshake.
module fetch_sequencer #(
  parameter logic [7:0] RESET_VECTOR = 8'h00
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [7:0] pc_count,
  output logic       pc_clear,
  output logic       pc_load,
  output logic       pc_enable,
  output logic [7:0] pc_data,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       branch_req,
  input  logic [7:0] branch_target,
  input  logic       halt_req,
  output logic       halted
);

  typedef enum logic [2:0] {INIT, LOAD, FETCH, HOLD, HALT} state_t;

  state_t     state, state_d;
  logic       pc_clear_d, pc_load_d, pc_enable_d, mem_req_d, instr_valid_d, halted_d;
  logic [7:0] pc_data_d, mem_addr_d, instr_d;
  logic       handshake;

  assign handshake = instr_valid & instr_ready;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= INIT;
      pc_clear    <= 1'b1;
      pc_load     <= 1'b0;
      pc_enable   <= 1'b0;
      pc_data     <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_d;
      pc_clear    <= pc_clear_d;
      pc_load     <= pc_load_d;
      pc_enable   <= pc_enable_d;
      pc_data     <= pc_data_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      halted      <= halted_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      INIT:  state_d = LOAD;
      LOAD:  state_d = FETCH;
      FETCH: if (mem_ack) state_d = HOLD;
      HOLD: begin
        if (branch_req)     state_d = LOAD;
        else if (handshake) state_d = halt_req ? HALT : FETCH;
      end
      HALT:  state_d = HALT;
      default: state_d = INIT;
    endcase
  end

  // Outputs are registered from the next state. mem_addr anticipates the PC
  // register: it takes the loaded value after LOAD and the incremented value
  // when HOLD is left in the same cycle as the pc_enable pulse.
  always_comb begin
    pc_clear_d    = 1'b0;
    pc_load_d     = 1'b0;
    pc_enable_d   = 1'b0;
    mem_req_d     = 1'b0;
    instr_valid_d = 1'b0;
    halted_d      = 1'b0;
    pc_data_d     = pc_data;
    mem_addr_d    = mem_addr;
    instr_d       = instr;
    case (state_d)
      INIT: pc_clear_d = 1'b1;
      LOAD: begin
        pc_load_d = 1'b1;
        pc_data_d = (state == INIT) ? RESET_VECTOR : branch_target;
      end
      FETCH: begin
        mem_req_d = 1'b1;
        if (state == LOAD)      mem_addr_d = pc_data;
        else if (state == HOLD) mem_addr_d = pc_enable ? pc_count + 8'd1 : pc_count;
      end
      HOLD: begin
        instr_valid_d = 1'b1;
        if (state == FETCH) begin
          pc_enable_d = 1'b1;
          instr_d     = mem_rdata;
        end
      end
      HALT: halted_d = 1'b1;
      default: pc_clear_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a PC register model and a
// memory responder whose data byte is addr ^ 8'hC3.
module tb_fetch_sequencer;

  logic       clk;
  logic       clear_n;
  logic [7:0] pc_q;
  logic       pc_clear, pc_load, pc_enable;
  logic [7:0] pc_data;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_req;
  logic [7:0] branch_target;
  logic       halt_req;
  logic       halted;

  fetch_sequencer #(.RESET_VECTOR(8'h10)) dut (
    .clk(clk), .clear_n(clear_n), .pc_count(pc_q),
    .pc_clear(pc_clear), .pc_load(pc_load), .pc_enable(pc_enable), .pc_data(pc_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_req(branch_req), .branch_target(branch_target),
    .halt_req(halt_req), .halted(halted)
  );

  typedef struct {
    logic [7:0]  addr;
    int unsigned stall;
  } fetch_t;

  logic [7:0]  exp_load[$];
  fetch_t      exp_fetch[$];
  logic [7:0]  exp_instr[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          n_hs = 0;
  int unsigned ack_delay = 0;
  logic        tp_check = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register the sequencer commands
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n)       pc_q <= 8'h00;
    else if (pc_clear)  pc_q <= 8'h00;
    else if (pc_load)   pc_q <= pc_data;
    else if (pc_enable) pc_q <= pc_q + 8'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory responder: acks after ack_delay stalled cycles
  initial begin
    int unsigned wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr ^ 8'hC3;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 8'h00;
          wcnt++;
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wcnt      = 0;
      end
    end
  end

  // Monitor: pops expectations as the DUT presents events, plus invariants
  initial begin
    int          cyc, last_hs;
    logic        have_last, prev_ok, prev_req, prev_ack, prev_iv;
    logic [7:0]  prev_addr, prev_instr;
    int unsigned stall;
    fetch_t      f;
    logic [7:0]  e;
    cyc = 0; last_hs = 0; have_last = 1'b0; prev_ok = 1'b0; stall = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_iv = 1'b0; prev_addr = '0; prev_instr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!clear_n) begin
        prev_ok = 1'b0;
        have_last = 1'b0;
        stall = 0;
      end else begin
        chk("cmd_onehot", 32'($countones({pc_clear, pc_load, pc_enable}) <= 1), 1);
        if (mem_req) chk("mem_addr_eq_pc", mem_addr, pc_q);
        if (mem_req || instr_valid || halted)
          chk("state_excl", 32'($countones({mem_req, instr_valid, halted})), 1);
        if (prev_ok) begin
          chk("pc_enable_first_hold", pc_enable, instr_valid & ~prev_iv);
          if (!(prev_req && prev_ack)) chk("instr_stable", instr, prev_instr);
          if (mem_req && prev_req) chk("mem_addr_stable", mem_addr, prev_addr);
        end
        if (pc_load) begin
          if (exp_load.size() == 0) chk("unexpected_load", pc_data, 32'hFFFF);
          else begin
            e = exp_load.pop_front();
            chk("pc_data", pc_data, e);
          end
        end
        if (mem_req && !mem_ack) stall++;
        if (mem_req && mem_ack) begin
          if (exp_fetch.size() == 0) chk("unexpected_fetch", mem_addr, 32'hFFFF);
          else begin
            f = exp_fetch.pop_front();
            chk("fetch_addr", mem_addr, f.addr);
            chk("fetch_stall", stall, f.stall);
          end
          stall = 0;
        end
        if (instr_valid && instr_ready && !branch_req) begin
          n_hs++;
          if (exp_instr.size() == 0) chk("unexpected_instr", instr, 32'hFFFF);
          else begin
            e = exp_instr.pop_front();
            chk("instr", instr, e);
          end
          if (tp_check && have_last) chk("throughput_cycles", cyc - last_hs, 2);
          have_last = 1'b1;
          last_hs = cyc;
        end
        prev_ok = 1'b1;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_iv = instr_valid;
      prev_addr = mem_addr; prev_instr = instr;
    end
  end

  initial begin
    clear_n = 1'b1;
    instr_ready = 1'b0; branch_req = 1'b0; branch_target = 8'h00; halt_req = 1'b0;
    #1 clear_n = 1'b0;
    #1;
    chk("rst_pc_clear", pc_clear, 1);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_enable", pc_enable, 0);
    chk("rst_pc_data", pc_data, 8'h00);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);

    // Reset vector fetch then sequential fetch with ready tied high
    @(negedge clk);
    tp_check = 1'b1; instr_ready = 1'b1; ack_delay = 0;
    exp_load.push_back(8'h10);
    exp_fetch.push_back('{8'h10, 0}); exp_fetch.push_back('{8'h11, 0});
    exp_fetch.push_back('{8'h12, 0}); exp_fetch.push_back('{8'h13, 0});
    exp_instr.push_back(8'hD3); exp_instr.push_back(8'hD2); exp_instr.push_back(8'hD1);
    #1 clear_n = 1'b1;
    #1 chk("init_pc_clear", pc_clear, 1);
    chk("init_pc_load", pc_load, 0);
    @(negedge clk);
    chk("load_pc_clear", pc_clear, 0);
    chk("load_pc_load", pc_load, 1);
    for (int i = 0; i < 100 && n_hs < 3; i++) tick();
    chk("seq_hs_reached", n_hs >= 3, 1);
    instr_ready = 1'b0; tp_check = 1'b0;

    // Branch to 8'h40 while a handshake is offered; slow memory
    for (int i = 0; i < 50 && !instr_valid; i++) tick();
    chk("hold_d0_valid", instr_valid, 1);
    branch_req = 1'b1; branch_target = 8'h40; instr_ready = 1'b1; ack_delay = 5;
    exp_load.push_back(8'h40);
    exp_fetch.push_back('{8'h40, 5}); exp_fetch.push_back('{8'h41, 5});
    exp_instr.push_back(8'h83);
    tick();
    branch_req = 1'b0;
    chk("branch_drop_valid", instr_valid, 0);
    for (int i = 0; i < 100 && n_hs < 4; i++) tick();
    chk("branch_hs_reached", n_hs >= 4, 1);
    instr_ready = 1'b0;

    // Branch with ready low to 8'hFF, wrap to 8'h00, then halt
    for (int i = 0; i < 50 && !instr_valid; i++) tick();
    chk("hold_82_valid", instr_valid, 1);
    branch_req = 1'b1; branch_target = 8'hFF; ack_delay = 0;
    exp_load.push_back(8'hFF);
    exp_fetch.push_back('{8'hFF, 0}); exp_fetch.push_back('{8'h00, 0});
    exp_instr.push_back(8'h3C); exp_instr.push_back(8'hC3);
    tick();
    branch_req = 1'b0; instr_ready = 1'b1;
    chk("branch2_drop_valid", instr_valid, 0);
    for (int i = 0; i < 100 && n_hs < 5; i++) tick();
    chk("wrap_hs_reached", n_hs >= 5, 1);
    halt_req = 1'b1;
    for (int i = 0; i < 50 && !halted; i++) tick();
    chk("halted_reached", halted, 1);
    halt_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_mem_req", mem_req, 0);
    end

    // Reset mid-FETCH with an outstanding request, then restart
    @(negedge clk);
    clear_n = 1'b0; ack_delay = 20; instr_ready = 1'b0;
    exp_load.push_back(8'h10);
    @(negedge clk);
    #1 clear_n = 1'b1;
    for (int i = 0; i < 20 && !mem_req; i++) tick();
    chk("refetch_req", mem_req, 1);
    repeat (3) @(negedge clk);
    #3 clear_n = 1'b0;
    #1;
    chk("mid_mem_req", mem_req, 0);
    chk("mid_pc_clear", pc_clear, 1);
    chk("mid_pc_load", pc_load, 0);
    chk("mid_pc_enable", pc_enable, 0);
    chk("mid_pc_data", pc_data, 8'h00);
    chk("mid_instr", instr, 8'h00);
    chk("mid_instr_valid", instr_valid, 0);
    chk("mid_halted", halted, 0);
    ack_delay = 0;
    exp_load.push_back(8'h10);
    exp_fetch.push_back('{8'h10, 0});
    repeat (2) @(negedge clk);
    #1 clear_n = 1'b1;
    for (int i = 0; i < 20 && !instr_valid; i++) tick();
    chk("restart_valid", instr_valid, 1);
    chk("restart_instr", instr, 8'hD3);
    repeat (3) @(negedge clk);
    chk("restart_hold_instr", instr, 8'hD3);
    chk("left_loads", exp_load.size(), 0);
    chk("left_fetches", exp_fetch.size(), 0);
    chk("left_instrs", exp_instr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
